// File: rtl/sync_pkt_fifo.sv
// sync_pkt_fifo: single-clock FIFO with optional packet commit, level and error flags.
//   CLK / RST            clock, asynchronous active-low reset
//   W_INC, WR_DATA       write request and data
//   WR_LAST, WR_DROP     packet end marker / discard open packet (packet mode only)
//   FULL, ALMOST_FULL    computed from occupied words (committed + uncommitted)
//   R_INC, RD_DATA       read request, registered read data (1-cycle latency)
//   EMPTY, ALMOST_EMPTY  computed from committed readable words
//   LEVEL                committed readable word count
//   OVERFLOW, UNDERFLOW  sticky error flags, cleared by CLR_ERR
module sync_pkt_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 2,
    parameter int PKT_MODE   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_LAST,
    input  logic                  WR_DROP,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  CLR_ERR
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AFULL_TH);
    localparam logic [PW-1:0] AE_P    = PW'(AEMPTY_TH);

    typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_t;

    state_t                state;
    logic [PW-1:0]         wr_ptr, cmt_ptr, rd_ptr;
    logic [PW-1:0]         occ, lvl;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic drop, wr_try, wr_ok, wr_ovf, rd_ok, rd_unf;

    // wr_ptr runs ahead of cmt_ptr while a packet is open; the reader only sees cmt_ptr.
    assign occ          = wr_ptr - rd_ptr;
    assign lvl          = cmt_ptr - rd_ptr;
    assign FULL         = (occ == DEPTH_P);
    assign ALMOST_FULL  = (occ >= AF_P);
    assign EMPTY        = (cmt_ptr == rd_ptr);
    assign LEVEL        = lvl;
    assign ALMOST_EMPTY = (lvl <= AE_P);

    always_comb begin
        // A drop swallows the beat presented alongside it; DISCARD ignores all beats.
        drop   = (PKT_MODE != 0) && WR_DROP;
        wr_try = W_INC && !drop && (state != DISCARD);
        wr_ok  = wr_try && !FULL;
        wr_ovf = wr_try && FULL;
        rd_ok  = R_INC && !EMPTY;
        rd_unf = R_INC && EMPTY;
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= WR_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            cmt_ptr   <= '0;
            rd_ptr    <= '0;
            RD_DATA   <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (rd_ok) begin
                RD_DATA <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end

            if (PKT_MODE == 0) begin
                if (wr_ok) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    cmt_ptr <= wr_ptr + 1'b1;
                end
            end else if (drop) begin
                // In IDLE wr_ptr already equals cmt_ptr, so this is harmless there.
                wr_ptr <= cmt_ptr;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_ok) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (WR_LAST) cmt_ptr <= wr_ptr + 1'b1;
                            else         state   <= IN_PKT;
                        end
                    end
                    IN_PKT: begin
                        if (wr_ok) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (WR_LAST) begin
                                cmt_ptr <= wr_ptr + 1'b1;
                                state   <= IDLE;
                            end
                        end else if (wr_ovf) begin
                            // Packet cannot fit: roll back and swallow the rest of it.
                            wr_ptr <= cmt_ptr;
                            state  <= WR_LAST ? IDLE : DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (W_INC && WR_LAST) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            // A new event in the same cycle beats the clear.
            OVERFLOW  <= wr_ovf | (OVERFLOW  & ~CLR_ERR);
            UNDERFLOW <= rd_unf | (UNDERFLOW & ~CLR_ERR);
        end
    end
endmodule
